imm_gen_pipe: RTL and testbench
===============================

Name: imm_gen_pipe

Overview:
Registered, parametrised immediate generator for the decode stage of the pipelined core.
- Accepts one 32-bit instruction per cycle over a valid/ready handshake.
- Decodes the I/S/B/U/J/Z immediate, sign-extended to XLEN.
- Presents the immediate with a format code and an illegal flag one cycle later.
- A 2-entry skid buffer keeps in_ready a registered signal, so stalls do not form a combinational path back to fetch.

Parameters:
XLEN, 32, datapath width; legal values 32 or 64.
EN_RV64_OPS, 0, when 1 (XLEN=64 only) opcode 0011011 (OP-IMM-32) decodes as I-type; otherwise it is illegal.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous, active-high reset.
flush  in  1  synchronous; drops both held entries.
in_valid  in  1  instruction present.
in_ready  out  1  block can accept; equals NOT skid_valid (registered).
in_instr  in  32  instruction word.
out_valid  out  1  out_imm, out_fmt and out_illegal are valid.
out_ready  in  1  consumer takes the output this cycle.
out_imm  out  XLEN  decoded immediate.
out_fmt  out  3  0=I, 1=S, 2=B, 3=U, 4=J, 5=Z, 7=none.
out_illegal  out  1  opcode not decodable.

Behaviour:
- Reset (async, rst=1): out_valid=0, skid_valid=0, in_ready=1, out_imm=0, out_fmt=7, out_illegal=0.
- Decode (combinational on the entry being loaded):
  - I-type, opcodes 0010011 / 0000011 / 1100111: sext(instr[31:20]).
  - S-type, 0100011: sext({instr[31:25], instr[11:7]}).
  - B-type, 1100011: sext({instr[31], instr[7], instr[30:25], instr[11:8], 0}).
  - U-type, 0110111 / 0010111: sext({instr[31:12], 12'b0}); for XLEN=64 bits 63:32 copy instr[31].
  - J-type, 1101111: sext({instr[31], instr[19:12], instr[20], instr[30:21], 0}).
  - SYSTEM, 1110011: if instr[14]=1, fmt Z with zext(instr[19:15]); else fmt I with sext(instr[31:20]).
  - 0011011: fmt I only when EN_RV64_OPS=1 and XLEN=64.
  - instr[1:0]!=2'b11 or any other opcode: out_imm=0, fmt=7, illegal=1. Never X.
- Handshakes: in_fire = in_valid AND in_ready; out_fire = out_valid AND out_ready.
- Latency: 1 cycle from in_fire to out_valid when the output stage is free. Throughput: 1 per cycle with out_ready held high.
- Output stage loads when it is empty or out_fire:
  - from the skid entry if skid_valid;
  - else from the input if in_fire.
  - If neither source is available and out_fire, out_valid clears.
- Skid: in_fire while the output is full and not out_fire loads the skid entry (skid_valid=1, so in_ready=0 next cycle).
- Skid drain: on out_fire with skid_valid, the skid moves to the output and skid_valid=0. No input can fire that cycle because in_ready=0.
- Ordering: strictly FIFO. No entry is dropped or duplicated except by flush or rst.
- out_* data is held stable while out_valid=1 and out_ready=0.
- flush=1: out_valid=0 and skid_valid=0 next cycle; in_fire in the same cycle is discarded. flush has priority over all loads.
- rst mid-transfer: all held entries are lost immediately; outputs take their reset values asynchronously.
- Decode is done before the skid register, so both stages store decoded values (imm, fmt, illegal).

Test Plan:
1. XLEN=32, out_ready=1; in 0xFFF00093 (addi x1,x0,-1) -> next cycle out_valid=1, out_imm=0xFFFFFFFF, fmt=0, illegal=0.
2. Back-to-back, one per cycle: 0xFE000EE3 (beq -4), then 0x123450B7 (lui) -> 0xFFFFFFFC fmt=2, then 0x12345000 fmt=3, in consecutive cycles.
3. XLEN=64: 0x800000B7 -> 0xFFFFFFFF80000000 fmt=3. 0x7FF0009B with EN_RV64_OPS=1 -> 0x00000000000007FF fmt=0; same input with EN_RV64_OPS=0 -> imm 0, illegal=1.
4. out_ready=0; offer A, B, C -> A held at output, B in skid, in_ready=0 and C waits. Set out_ready=1 -> A, B, C emitted in order over 3 cycles; in_ready returns to 1 one cycle after B leaves the skid.
5. 0x01FFD073 (csrrwi, rs1=31) -> imm 0x1F, fmt=5. 0x00000000 -> imm 0, fmt=7, illegal=1.
6. Output and skid both full: pulse flush -> out_valid=0, in_ready=1 next cycle. Repeat with rst asserted mid-cycle -> outputs clear without waiting for a clock edge.

Source files
------------

// File: rtl/imm_gen_pipe.sv
// Decode-stage immediate generator: decodes one instruction per cycle into a
// registered output stage backed by a single skid entry so in_ready is a flop.
module imm_gen_pipe #(
  parameter int unsigned XLEN        = 32,
  parameter bit          EN_RV64_OPS = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic            out_illegal
);

  typedef enum logic [2:0] {
    FMT_I    = 3'd0,
    FMT_S    = 3'd1,
    FMT_B    = 3'd2,
    FMT_U    = 3'd3,
    FMT_J    = 3'd4,
    FMT_Z    = 3'd5,
    FMT_NONE = 3'd7
  } fmt_e;

  logic [XLEN-1:0] dec_imm;
  fmt_e            dec_fmt;
  logic            dec_ill;

  logic            out_valid_q, out_valid_d;
  logic [XLEN-1:0] out_imm_q, out_imm_d;
  fmt_e            out_fmt_q, out_fmt_d;
  logic            out_ill_q, out_ill_d;

  logic            skid_valid_q, skid_valid_d;
  logic [XLEN-1:0] skid_imm_q, skid_imm_d;
  fmt_e            skid_fmt_q, skid_fmt_d;
  logic            skid_ill_q, skid_ill_d;

  logic in_fire, out_fire, out_load;

  always_comb begin
    dec_imm = '0;
    dec_fmt = FMT_NONE;
    dec_ill = 1'b1;
    if (in_instr[1:0] == 2'b11) begin
      unique case (in_instr[6:0])
        7'b0010011, 7'b0000011, 7'b1100111: begin
          dec_imm = XLEN'($signed(in_instr[31:20]));
          dec_fmt = FMT_I;
          dec_ill = 1'b0;
        end
        7'b0100011: begin
          dec_imm = XLEN'($signed({in_instr[31:25], in_instr[11:7]}));
          dec_fmt = FMT_S;
          dec_ill = 1'b0;
        end
        7'b1100011: begin
          dec_imm = XLEN'($signed({in_instr[31], in_instr[7], in_instr[30:25],
                                   in_instr[11:8], 1'b0}));
          dec_fmt = FMT_B;
          dec_ill = 1'b0;
        end
        7'b0110111, 7'b0010111: begin
          dec_imm = XLEN'($signed({in_instr[31:12], 12'b0}));
          dec_fmt = FMT_U;
          dec_ill = 1'b0;
        end
        7'b1101111: begin
          dec_imm = XLEN'($signed({in_instr[31], in_instr[19:12], in_instr[20],
                                   in_instr[30:21], 1'b0}));
          dec_fmt = FMT_J;
          dec_ill = 1'b0;
        end
        7'b1110011: begin
          // CSR immediate forms carry a 5-bit unsigned uimm in the rs1 field
          if (in_instr[14]) begin
            dec_imm = XLEN'(in_instr[19:15]);
            dec_fmt = FMT_Z;
          end else begin
            dec_imm = XLEN'($signed(in_instr[31:20]));
            dec_fmt = FMT_I;
          end
          dec_ill = 1'b0;
        end
        7'b0011011: begin
          if (EN_RV64_OPS && (XLEN == 64)) begin
            dec_imm = XLEN'($signed(in_instr[31:20]));
            dec_fmt = FMT_I;
            dec_ill = 1'b0;
          end
        end
        default: begin
          dec_imm = '0;
          dec_fmt = FMT_NONE;
          dec_ill = 1'b1;
        end
      endcase
    end
  end

  assign in_ready = ~skid_valid_q;
  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid_q & out_ready;
  assign out_load = ~out_valid_q | out_fire;

  always_comb begin
    out_valid_d  = out_valid_q;
    out_imm_d    = out_imm_q;
    out_fmt_d    = out_fmt_q;
    out_ill_d    = out_ill_q;
    skid_valid_d = skid_valid_q;
    skid_imm_d   = skid_imm_q;
    skid_fmt_d   = skid_fmt_q;
    skid_ill_d   = skid_ill_q;
    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else begin
      if (out_load) begin
        if (skid_valid_q) begin
          out_valid_d  = 1'b1;
          out_imm_d    = skid_imm_q;
          out_fmt_d    = skid_fmt_q;
          out_ill_d    = skid_ill_q;
          skid_valid_d = 1'b0;
        end else if (in_fire) begin
          out_valid_d = 1'b1;
          out_imm_d   = dec_imm;
          out_fmt_d   = dec_fmt;
          out_ill_d   = dec_ill;
        end else begin
          out_valid_d = 1'b0;
        end
      end
      // in_fire implies the skid is empty, so it only fills while output stalls
      if (in_fire && !out_load) begin
        skid_valid_d = 1'b1;
        skid_imm_d   = dec_imm;
        skid_fmt_d   = dec_fmt;
        skid_ill_d   = dec_ill;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      out_imm_q    <= '0;
      out_fmt_q    <= FMT_NONE;
      out_ill_q    <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_imm_q   <= '0;
      skid_fmt_q   <= FMT_NONE;
      skid_ill_q   <= 1'b0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_imm_q    <= out_imm_d;
      out_fmt_q    <= out_fmt_d;
      out_ill_q    <= out_ill_d;
      skid_valid_q <= skid_valid_d;
      skid_imm_q   <= skid_imm_d;
      skid_fmt_q   <= skid_fmt_d;
      skid_ill_q   <= skid_ill_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_imm     = out_imm_q;
  assign out_fmt     = out_fmt_q;
  assign out_illegal = out_ill_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: decode table on XLEN=32, RV64 variants,
// skid/backpressure ordering, flush and asynchronous reset.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_instr = '0;
  logic        out_ready = 1'b1;
  logic        in_ready, out_valid, out_illegal;
  logic [31:0] out_imm;
  logic [2:0]  out_fmt;

  logic        v64 = 1'b0;
  logic [31:0] instr64 = '0;
  logic        rdy_a, rdy_b, ov_a, ov_b, ill_a, ill_b;
  logic [63:0] imm_a, imm_b;
  logic [2:0]  fmt_a, fmt_b;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .EN_RV64_OPS(1'b0)) dut32 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_imm(out_imm), .out_fmt(out_fmt), .out_illegal(out_illegal)
  );

  imm_gen_pipe #(.XLEN(64), .EN_RV64_OPS(1'b1)) dut64a (
    .clk(clk), .rst(rst), .flush(1'b0),
    .in_valid(v64), .in_ready(rdy_a), .in_instr(instr64),
    .out_valid(ov_a), .out_ready(1'b1),
    .out_imm(imm_a), .out_fmt(fmt_a), .out_illegal(ill_a)
  );

  imm_gen_pipe #(.XLEN(64), .EN_RV64_OPS(1'b0)) dut64b (
    .clk(clk), .rst(rst), .flush(1'b0),
    .in_valid(v64), .in_ready(rdy_b), .in_instr(instr64),
    .out_valid(ov_b), .out_ready(1'b1),
    .out_imm(imm_b), .out_fmt(fmt_b), .out_illegal(ill_b)
  );

  typedef struct {
    logic [31:0] instr;
    logic [31:0] imm;
    logic [2:0]  fmt;
    logic        ill;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string name, input logic [31:0] imm, input logic [2:0] fmt,
                         input logic ill);
    chk({name, ".valid"}, 64'(out_valid), 64'd1);
    chk({name, ".imm"}, 64'(out_imm), 64'(imm));
    chk({name, ".fmt"}, 64'(out_fmt), 64'(fmt));
    chk({name, ".ill"}, 64'(out_illegal), 64'(ill));
  endtask

  initial begin
    vecs[0]  = '{32'hFFF00093, 32'hFFFFFFFF, 3'd0, 1'b0};
    vecs[1]  = '{32'hFE000EE3, 32'hFFFFFFFC, 3'd2, 1'b0};
    vecs[2]  = '{32'h123450B7, 32'h12345000, 3'd3, 1'b0};
    vecs[3]  = '{32'h01FFD073, 32'h0000001F, 3'd5, 1'b0};
    vecs[4]  = '{32'h00000000, 32'h00000000, 3'd7, 1'b1};
    vecs[5]  = '{32'hFE20AC23, 32'hFFFFFFF8, 3'd1, 1'b0};
    vecs[6]  = '{32'hFFDFF06F, 32'hFFFFFFFC, 3'd4, 1'b0};
    vecs[7]  = '{32'h34011073, 32'h00000340, 3'd0, 1'b0};
    vecs[8]  = '{32'hFFF00091, 32'h00000000, 3'd7, 1'b1};
    vecs[9]  = '{32'h0000007F, 32'h00000000, 3'd7, 1'b1};
    vecs[10] = '{32'h7FF0009B, 32'h00000000, 3'd7, 1'b1};
    vecs[11] = '{32'h80002103, 32'hFFFFF800, 3'd0, 1'b0};
    vecs[12] = '{32'h00008067, 32'h00000000, 3'd0, 1'b0};
    vecs[13] = '{32'hFFFFF097, 32'hFFFFF000, 3'd3, 1'b0};
    vecs[14] = '{32'h7FF00013, 32'h000007FF, 3'd0, 1'b0};

    #12;
    chk("rst.valid", 64'(out_valid), 64'd0);
    chk("rst.ready", 64'(in_ready), 64'd1);
    chk("rst.imm", 64'(out_imm), 64'd0);
    chk("rst.fmt", 64'(out_fmt), 64'd7);
    chk("rst.ill", 64'(out_illegal), 64'd0);
    rst = 1'b0;
    tick();

    // Back-to-back decode, one per cycle
    out_ready = 1'b1;
    for (int i = 0; i < 15; i++) begin
      in_valid = 1'b1;
      in_instr = vecs[i].instr;
      tick();
      chk_out($sformatf("vec%0d", i), vecs[i].imm, vecs[i].fmt, vecs[i].ill);
      chk($sformatf("vec%0d.in_ready", i), 64'(in_ready), 64'd1);
    end
    in_valid = 1'b0;
    tick();
    chk("drain.valid", 64'(out_valid), 64'd0);

    // XLEN=64 variants
    v64 = 1'b1;
    instr64 = 32'h800000B7;
    tick();
    chk("rv64.lui.imm", imm_a, 64'hFFFFFFFF80000000);
    chk("rv64.lui.fmt", 64'(fmt_a), 64'd3);
    chk("rv64b.lui.imm", imm_b, 64'hFFFFFFFF80000000);
    instr64 = 32'h7FF0009B;
    tick();
    chk("rv64.addiw.imm", imm_a, 64'h00000000000007FF);
    chk("rv64.addiw.fmt", 64'(fmt_a), 64'd0);
    chk("rv64.addiw.ill", 64'(ill_a), 64'd0);
    chk("rv64off.addiw.imm", imm_b, 64'd0);
    chk("rv64off.addiw.fmt", 64'(fmt_b), 64'd7);
    chk("rv64off.addiw.ill", 64'(ill_b), 64'd1);
    chk("rv64off.valid", 64'(ov_b), 64'd1);
    v64 = 1'b0;

    // Backpressure: A to output, B to skid, C waits
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = 32'hFFF00093;
    tick();
    chk_out("bp.A", 32'hFFFFFFFF, 3'd0, 1'b0);
    chk("bp.A.in_ready", 64'(in_ready), 64'd1);
    in_instr = 32'hFE20AC23;
    tick();
    chk_out("bp.Aheld", 32'hFFFFFFFF, 3'd0, 1'b0);
    chk("bp.B.in_ready", 64'(in_ready), 64'd0);
    in_instr = 32'h123450B7;
    tick();
    chk_out("bp.Aheld2", 32'hFFFFFFFF, 3'd0, 1'b0);
    chk("bp.C.in_ready", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    tick();
    chk_out("bp.B", 32'hFFFFFFF8, 3'd1, 1'b0);
    chk("bp.B.ready_back", 64'(in_ready), 64'd1);
    tick();
    chk_out("bp.C", 32'h12345000, 3'd3, 1'b0);
    in_valid = 1'b0;
    tick();
    chk("bp.empty", 64'(out_valid), 64'd0);

    // Flush with both stages full
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = 32'hFFF00093;
    tick();
    in_instr = 32'h123450B7;
    tick();
    chk("fl.full.in_ready", 64'(in_ready), 64'd0);
    in_valid = 1'b0;
    flush    = 1'b1;
    tick();
    flush = 1'b0;
    chk("fl.valid", 64'(out_valid), 64'd0);
    chk("fl.in_ready", 64'(in_ready), 64'd1);
    // Input offered during flush is discarded
    in_valid = 1'b1;
    flush    = 1'b1;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("fl.discard.valid", 64'(out_valid), 64'd0);
    tick();
    chk("fl.discard.valid2", 64'(out_valid), 64'd0);

    // Asynchronous reset between clock edges
    in_valid = 1'b1;
    in_instr = 32'hFFF00093;
    tick();
    in_instr = 32'hFE000EE3;
    tick();
    in_valid = 1'b0;
    chk("ar.full.in_ready", 64'(in_ready), 64'd0);
    #1;
    rst = 1'b1;
    #1;
    chk("ar.valid", 64'(out_valid), 64'd0);
    chk("ar.in_ready", 64'(in_ready), 64'd1);
    chk("ar.imm", 64'(out_imm), 64'd0);
    chk("ar.fmt", 64'(out_fmt), 64'd7);
    chk("ar.ill", 64'(out_illegal), 64'd0);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("ar.after.valid", 64'(out_valid), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
